// File: rtl/fmap_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fmap_scan_ctrl
//
// Purpose:
//   Feature-map scan sequencer. It walks a map in the order row, then col, then
//   ch, with ch as the innermost loop. It presents one (row, col, ch) coordinate
//   and its linear address per valid/ready handshake. The layer controller
//   starts a scan with a one-cycle start pulse. The scan can be aborted.
//   A one-cycle done pulse follows the final transfer. Row and column advance
//   by STRIDE (1 or 2).
//
// Parameters:
//   IMG_W, IMG_H : map width / height in pixels
//   CH           : channels per pixel (>= 1)
//   STRIDE       : spatial step for row and col (1 or 2)
//   ADDR_W       : linear address width (must hold IMG_W*IMG_H*CH-1)
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle pulse, begins a scan when idle
//   abort      in   terminates an active scan, no done pulse
//   out_ready  in   datapath accepts the current coordinate
//   out_valid  out  coordinate/address valid (high while scanning)
//   row        out  current row
//   col        out  current column
//   ch         out  current channel
//   addr       out  (row*IMG_W + col)*CH + ch
//   first_pix  out  high with the first coordinate (0,0,0) of a scan
//   last_pix   out  high with the final coordinate of a scan
//   busy       out  high while scanning
//   done       out  one-cycle pulse after the final transfer
//   stall_cnt  out  [31:0] saturating count of stall cycles
//                   (present only when SCAN_PERF_EN is defined)
//
// Build option:
//   SCAN_PERF_EN - when defined, adds the stall_cnt output and its counter.
// -----------------------------------------------------------------------------
module fmap_scan_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640,
  parameter int CH     = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 21
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [$clog2(IMG_H)-1:0]             row,
  output logic [$clog2(IMG_W)-1:0]             col,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch,
  output logic [ADDR_W-1:0]                    addr,
  output logic                                 first_pix,
  output logic                                 last_pix,
  output logic                                 busy,
  output logic                                 done
`ifdef SCAN_PERF_EN
  ,
  output logic [31:0]                          stall_cnt
`endif
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

  // Last row/column actually visited: the largest multiple of STRIDE that
  // still lies inside the map.
  localparam int LR = ((IMG_H - 1) / STRIDE) * STRIDE;
  localparam int LC = ((IMG_W - 1) / STRIDE) * STRIDE;

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(LR);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(LC);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CH - 1);
  localparam logic [ROW_W-1:0]  ROW_STEP = ROW_W'(STRIDE);
  localparam logic [COL_W-1:0]  COL_STEP = COL_W'(STRIDE);

  // Address deltas for the incremental address update.
  // Column advance: from (c, CH-1) to (c+STRIDE, 0) is (STRIDE-1)*CH + 1.
  // Row advance: the new address is the start of row r+STRIDE. It is taken
  // from a separately tracked row base, so the skipped columns in
  // stride-2 mode need no extra correction term.
  localparam logic [ADDR_W-1:0] ADDR_COL_STEP = ADDR_W'((STRIDE - 1) * CH + 1);
  localparam logic [ADDR_W-1:0] ADDR_ROW_STEP = ADDR_W'(STRIDE * IMG_W * CH);

  // A degenerate 1x1x1 map has its first coordinate equal to its last.
  localparam logic FIRST_IS_LAST = (LR == 0) && (LC == 0) && (CH == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] row_base_reg;   // address of (row_reg, 0, 0)
  logic              first_reg;
  logic              last_reg;

  // Candidate next coordinate for a transfer (not the final one).
  logic [ROW_W-1:0]  row_adv;
  logic [COL_W-1:0]  col_adv;
  logic [CH_W-1:0]   ch_adv;
  logic [ADDR_W-1:0] addr_adv;
  logic [ADDR_W-1:0] base_adv;
  logic              last_adv;

  logic start_accept;
  logic xfer;
  logic abort_run;

  assign start_accept = (state_reg == S_IDLE) && start;
  assign xfer         = (state_reg == S_RUN) && out_ready;
  assign abort_run    = (state_reg == S_RUN) && abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over a transfer in the same cycle
        if (abort) begin
          state_next = S_IDLE;
        end else if (out_ready && last_reg) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (decoded from registered state and datapath registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (state_reg == S_RUN);
    busy      = (state_reg == S_RUN);
    done      = (state_reg == S_DONE);
    row       = row_reg;
    col       = col_reg;
    ch        = ch_reg;
    addr      = addr_reg;
    first_pix = first_reg;
    last_pix  = last_reg;
  end

  // ---------------------------------------------------------------------------
  // Coordinate advance. ch is the innermost loop. A ch wrap steps col, and a
  // col wrap steps row. With CH=1 the ch compare is always true, so ch stays
  // 0 and every transfer steps col.
  // ---------------------------------------------------------------------------
  always_comb begin
    row_adv  = row_reg;
    col_adv  = col_reg;
    ch_adv   = ch_reg + 1'b1;
    addr_adv = addr_reg + 1'b1;
    base_adv = row_base_reg;
    if (ch_reg == LAST_CH) begin
      ch_adv = '0;
      if (col_reg == LAST_COL) begin
        col_adv  = '0;
        row_adv  = row_reg + ROW_STEP;
        base_adv = row_base_reg + ADDR_ROW_STEP;
        addr_adv = base_adv;
      end else begin
        col_adv  = col_reg + COL_STEP;
        addr_adv = addr_reg + ADDR_COL_STEP;
      end
    end
    last_adv = (row_adv == LAST_ROW) && (col_adv == LAST_COL) && (ch_adv == LAST_CH);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. During a stall, neither branch fires, so the
  // coordinate, address and markers hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg      <= '0;
      col_reg      <= '0;
      ch_reg       <= '0;
      addr_reg     <= '0;
      row_base_reg <= '0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
    end else if (start_accept) begin
      row_reg      <= '0;
      col_reg      <= '0;
      ch_reg       <= '0;
      addr_reg     <= '0;
      row_base_reg <= '0;
      first_reg    <= 1'b1;
      last_reg     <= FIRST_IS_LAST;
    end else if (abort_run || (xfer && last_reg)) begin
      // Scan ends: either aborted or the final coordinate was accepted.
      row_reg      <= '0;
      col_reg      <= '0;
      ch_reg       <= '0;
      addr_reg     <= '0;
      row_base_reg <= '0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
    end else if (xfer) begin
      row_reg      <= row_adv;
      col_reg      <= col_adv;
      ch_reg       <= ch_adv;
      addr_reg     <= addr_adv;
      row_base_reg <= base_adv;
      first_reg    <= 1'b0;
      last_reg     <= last_adv;
    end
  end

`ifdef SCAN_PERF_EN
  // ---------------------------------------------------------------------------
  // Stall counter. It counts cycles where a coordinate is offered but not
  // taken. It clears when a scan is accepted, saturates at all-ones, and
  // holds its value after the scan ends.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (start_accept) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == S_RUN) && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
